// File: rtl/div_sequencer.sv
// div_sequencer
//
// Multi-cycle integer divider for the EX-stage B slot. It computes the quotient
// and remainder of a 32-bit divide, signed or unsigned, with radix-2
// restoring division. The divider produces one quotient bit per cycle, MSB
// first. While a division runs, stall_div holds the front of the pipeline.
//
// Handshake: EX_div_req is a request that stays asserted, and stall_div is
// its inverse "ready". A request is taken in any IDLE cycle with flush low,
// and stall_div is high in that same cycle so the instruction stays in EX.
// stall_div stays high for the whole CALC phase. In the DONE cycle,
// stall_div is low and div_done pulses, so the held instruction moves on
// with div_quo/div_rem on the same edge. Requests seen in CALC or DONE are
// ignored.
//
// Ports
//   clk            pipeline clock, rising edge
//   rstn           asynchronous active-low reset
//   EX_div_req     divide/modulo request from EX
//   EX_div_signed  1 = signed operands, 0 = unsigned
//   EX_div_src1    dividend
//   EX_div_src2    divisor
//   flush          pipeline flush; aborts a division in CALC
//   stall_div      freeze IF..EX and EX/MEM while dividing
//   div_done       one-cycle pulse, div_quo/div_rem valid
//   div_quo        quotient, held until the next result
//   div_rem        remainder, held until the next result
//   dbg_state      current FSM state (0 IDLE, 1 CALC, 2 DONE)

module div_sequencer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        EX_div_req,
    input  logic        EX_div_signed,
    input  logic [31:0] EX_div_src1,
    input  logic [31:0] EX_div_src2,
    input  logic        flush,
    output logic        stall_div,
    output logic        div_done,
    output logic [31:0] div_quo,
    output logic [31:0] div_rem,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [32:0] prem;     // partial remainder
    logic [31:0] dvd;      // dividend bits shift out, quotient bits shift in
    logic [31:0] dvs;      // divisor magnitude
    logic        quo_neg;
    logic        rem_neg;

    logic        accept;
    logic        s1;
    logic        s2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [33:0] shifted;
    logic [33:0] diff;
    logic        q_bit;
    logic [32:0] next_prem;
    logic [31:0] next_dvd;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign accept = (state == IDLE) && EX_div_req && !flush;

    // Combinational so the request cycle itself is stalled. Reset masks it
    // because the FSM reads IDLE during reset.
    assign stall_div = rstn && (accept || (state == CALC));
    assign dbg_state = state;

    // Operand magnitudes and result signs, latched on acceptance.
    always_comb begin
        s1   = EX_div_signed & EX_div_src1[31];
        s2   = EX_div_signed & EX_div_src2[31];
        mag1 = s1 ? (~EX_div_src1 + 32'd1) : EX_div_src1;
        mag2 = s2 ? (~EX_div_src2 + 32'd1) : EX_div_src2;
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value fits in 33 bits. Bit 33 of the difference is
    // therefore a clean borrow, which means "does not go".
    always_comb begin
        shifted   = {prem, dvd[31]};
        diff      = shifted - {2'b00, dvs};
        q_bit     = ~diff[33];
        next_prem = q_bit ? diff[32:0] : shifted[32:0];
        next_dvd  = {dvd[30:0], q_bit};
        q_fix     = quo_neg ? (~next_dvd + 32'd1) : next_dvd;
        r_fix     = rem_neg ? (~next_prem[31:0] + 32'd1) : next_prem[31:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            prem     <= 33'd0;
            dvd      <= 32'd0;
            dvs      <= 32'd0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_done <= 1'b0;
            div_quo  <= 32'd0;
            div_rem  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        quo_neg <= s1 ^ s2;
                        rem_neg <= s1;
                        dvd     <= mag1;
                        dvs     <= mag2;
                        prem    <= 33'd0;
                        cnt     <= 5'd0;
                        if (EX_div_src2 == 32'd0) begin
                            // Divide by zero skips the iteration entirely.
                            state    <= DONE;
                            div_done <= 1'b1;
                            div_quo  <= 32'hFFFF_FFFF;
                            div_rem  <= EX_div_src1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (flush) begin
                        // Abort: previous results stay visible.
                        state <= IDLE;
                    end else begin
                        prem <= next_prem;
                        dvd  <= next_dvd;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state    <= DONE;
                            div_done <= 1'b1;
                            div_quo  <= q_fix;
                            div_rem  <= r_fix;
                        end
                    end
                end

                DONE: begin
                    // The instruction has already left EX, so a flush here
                    // changes nothing.
                    div_done <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    div_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Testbench for div_sequencer: directed divides with hand-computed results,
// latency/stall profile, flush, asynchronous reset and back-to-back requests.

module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        done;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [1:0]  st;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    div_sequencer dut (
        .clk           (clk),
        .rstn          (rstn),
        .EX_div_req    (req),
        .EX_div_signed (sgn),
        .EX_div_src1   (src1),
        .EX_div_src2   (src2),
        .flush         (flush),
        .stall_div     (stall),
        .div_done      (done),
        .div_quo       (quo),
        .div_rem       (rem),
        .dbg_state     (st)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- divide driver with inline checks ----------------
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input int lat, input logic rel);
        int   n;
        int   done_at;
        int   stall_cnt;
        logic done_stall;
        @(posedge clk); #1;
        if (rel) rstn = 1'b1;
        req = 1'b1; sgn = s; src1 = a; src2 = b;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL %s stall_req: got %b want 1", tag, stall);
        end
        @(posedge clk); #1;
        req = 1'b0; src1 = $urandom; src2 = $urandom;
        n = 0; done_at = 0; stall_cnt = 0; done_stall = 1'b0;
        while (done_at == 0 && n < 40) begin
            @(negedge clk); n++;
            if (stall === 1'b1) stall_cnt++;
            if (done === 1'b1) begin
                done_at = n; done_stall = stall; last_done_cyc = cyc;
            end
        end
        n_cmp++;
        if (done_at !== lat) begin
            n_bad++; $display("FAIL %s done_latency: got %0d want %0d", tag, done_at, lat);
        end
        n_cmp++;
        if (stall_cnt !== lat - 1) begin
            n_bad++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cnt, lat - 1);
        end
        n_cmp++;
        if (done_stall !== 1'b0) begin
            n_bad++; $display("FAIL %s stall_in_done: got %b want 0", tag, done_stall);
        end
        n_cmp++;
        if (quo !== eq) begin
            n_bad++; $display("FAIL %s quo: got %h want %h", tag, quo, eq);
        end
        n_cmp++;
        if (rem !== er) begin
            n_bad++; $display("FAIL %s rem: got %h want %h", tag, rem, er);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0; req = 1'b1; sgn = 1'b0; src1 = 32'd5; src2 = 32'd1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++;
        if (quo !== 32'd0) begin n_bad++; $display("FAIL reset_quo: got %h want 0", quo); end
        n_cmp++;
        if (rem !== 32'd0) begin n_bad++; $display("FAIL reset_rem: got %h want 0", rem); end
        n_cmp++;
        if (st !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st); end
    endtask

    task automatic test_unsigned();
        // Accepted in the very cycle reset is released.
        do_div("u_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL u_pulse_width: got %b want 0", done); end
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL u_stall_after: got %b want 0", stall); end
        n_cmp++;
        if (quo !== 32'd14) begin n_bad++; $display("FAIL u_quo_hold: got %h want %h", quo, 32'd14); end
    endtask

    task automatic test_signed();
        do_div("s_m7_2",   32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        do_div("s_7_m2",   32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         33, 1'b0);
        do_div("s_m100_m7",32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE, 33, 1'b0);
        do_div("u_big_2",  32'hFFFF_FFF9, 32'd2,         1'b0, 32'h7FFF_FFFC, 32'd1,         33, 1'b0);
    endtask

    task automatic test_div_zero();
        do_div("z_5_0",  32'd5,         32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5,         1, 1'b0);
        do_div("z_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 1'b0);
    endtask

    task automatic test_overflow();
        do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, 1'b0);
    endtask

    task automatic test_flush_calc();
        @(posedge clk); #1;
        req = 1'b1; sgn = 1'b0; src1 = 32'd100; src2 = 32'd7;
        @(posedge clk); #1;
        req = 1'b0;                      // first CALC cycle
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;                 // tenth CALC cycle
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b1) begin n_bad++; $display("FAIL fl_stall_in_flush: got %b want 1", stall); end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_stall_after: got %b want 0", stall); end
        n_cmp++;
        if (st !== 2'd0) begin n_bad++; $display("FAIL fl_state: got %0d want 0", st); end
        n_cmp++;
        if (quo !== 32'h8000_0000) begin n_bad++; $display("FAIL fl_quo_keep: got %h want 80000000", quo); end
        n_cmp++;
        if (rem !== 32'd0) begin n_bad++; $display("FAIL fl_rem_keep: got %h want 0", rem); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL fl_no_done: got %b want 0", done); end
        do_div("fl_new_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b0);
    endtask

    task automatic test_flush_done();
        @(posedge clk); #1;
        req = 1'b1; sgn = 1'b0; src1 = 32'd200; src2 = 32'd9;
        @(posedge clk); #1;
        req = 1'b0;                      // first CALC cycle
        repeat (32) @(posedge clk);      // now in the DONE cycle
        #1 flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL fd_done: got %b want 1", done); end
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL fd_stall: got %b want 0", stall); end
        n_cmp++;
        if (quo !== 32'd22) begin n_bad++; $display("FAIL fd_quo: got %h want %h", quo, 32'd22); end
        n_cmp++;
        if (rem !== 32'd2) begin n_bad++; $display("FAIL fd_rem: got %h want %h", rem, 32'd2); end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL fd_pulse_width: got %b want 0", done); end
        n_cmp++;
        if (st !== 2'd0) begin n_bad++; $display("FAIL fd_state: got %0d want 0", st); end
    endtask

    task automatic test_reset_mid_calc();
        @(posedge clk); #1;
        req = 1'b1; sgn = 1'b0; src1 = 32'd100; src2 = 32'd7;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (5) @(posedge clk);
        #3 rstn = 1'b0;                  // asynchronous, between edges
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL rm_stall: got %b want 0", stall); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL rm_done: got %b want 0", done); end
        n_cmp++;
        if (quo !== 32'd0) begin n_bad++; $display("FAIL rm_quo: got %h want 0", quo); end
        n_cmp++;
        if (rem !== 32'd0) begin n_bad++; $display("FAIL rm_rem: got %h want 0", rem); end
        n_cmp++;
        if (st !== 2'd0) begin n_bad++; $display("FAIL rm_state: got %0d want 0", st); end
        do_div("rm_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 1'b1);
    endtask

    task automatic test_back_to_back();
        int c1;
        do_div("bb_50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33, 1'b0);
        c1 = last_done_cyc;
        do_div("bb_51_5", 32'd51, 32'd5, 1'b0, 32'd10, 32'd1, 33, 1'b0);
        n_cmp++;
        if (last_done_cyc - c1 !== 34) begin
            n_bad++; $display("FAIL bb_spacing: got %0d want 34", last_done_cyc - c1);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush_calc();
        test_flush_done();
        test_reset_mid_calc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
